// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg
// Shared types and constants for the maze player datapath.
//   dir_t        : requested movement direction decoded from the keyboard
//   move_state_t : player_move_ctrl step sequencer states
//   KEY_*        : USB HID keycodes for the W/A/S/D keys
//   SCREEN_*_DEF : default visible screen size in pixels
// ---------------------------------------------------------------------------
package maze_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_APPLY  = 2'd2
  } move_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

endpackage

// File: rtl/key_decode.sv
// ---------------------------------------------------------------------------
// key_decode
// Combinational keycode to direction decoder.
//   keycode : current USB HID keycode
//   dir     : DIR_UP/DOWN/LEFT/RIGHT for W/S/A/D, DIR_NONE for anything else
// ---------------------------------------------------------------------------
module key_decode
  import maze_pkg::*;
(
  input  logic [7:0] keycode,
  output dir_t       dir
);

  always_comb begin
    dir = DIR_NONE;
    case (keycode)
      KEY_W:   dir = DIR_UP;
      KEY_S:   dir = DIR_DOWN;
      KEY_A:   dir = DIR_LEFT;
      KEY_D:   dir = DIR_RIGHT;
      default: dir = DIR_NONE;
    endcase
  end

endmodule

// File: rtl/player_move_ctrl.sv
// ---------------------------------------------------------------------------
// player_move_ctrl
// Holds the player sprite bounding box and steps it one STEP at a time in
// response to the keyboard, once every FRAME_DIV frames a key is held.
// Each step takes three clock edges from the frame tick: the tick edge moves
// to SETTLE so the external deny checkers see a stable box, the next edge
// captures the relevant deny bit, and the APPLY edge either commits the step
// or refuses it (maze deny or screen edge).
//
// Ports:
//   Clk        : system clock
//   Reset      : synchronous active-high reset
//   frame_tick : one-Clk pulse per video frame
//   keycode    : USB HID keycode (W/A/S/D move, anything else = none)
//   deny_*     : move blocked by the maze, evaluated against the current box
//   top/bottom : sprite vertical edges (bottom = top + SPRITE_SIZE - 1)
//   left/right : sprite horizontal edges (right = left + SPRITE_SIZE - 1)
//   moving     : high while a step is being evaluated (SETTLE/APPLY)
//   blocked    : one-Clk pulse when a requested step is refused
//   move_count : committed steps, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module player_move_ctrl
  import maze_pkg::*;
#(
  parameter int START_X     = 16,
  parameter int START_Y     = 16,
  parameter int SPRITE_SIZE = 12,
  parameter int STEP        = 2,
  parameter int FRAME_DIV   = 2,
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [7:0]  keycode,
  input  logic        deny_up,
  input  logic        deny_down,
  input  logic        deny_left,
  input  logic        deny_right,
  output logic [9:0]  top,
  output logic [9:0]  bottom,
  output logic [9:0]  left,
  output logic [9:0]  right,
  output logic        moving,
  output logic        blocked,
  output logic [15:0] move_count
);

  // A one-frame divider still needs a one-bit counter to stay legal.
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  // Screen-bound checks are done one bit wider than the position so that
  // bottom/right + STEP cannot wrap past 1023 and look in-bounds.
  localparam logic [10:0] STEP_EXT  = 11'(STEP);
  localparam logic [10:0] SIZE_M1   = 11'(SPRITE_SIZE - 1);
  localparam logic [10:0] MAX_X_EXT = 11'(SCREEN_W - 1);
  localparam logic [10:0] MAX_Y_EXT = 11'(SCREEN_H - 1);

  localparam logic [9:0] START_X_POS = 10'(START_X);
  localparam logic [9:0] START_Y_POS = 10'(START_Y);
  localparam logic [9:0] STEP_POS    = 10'(STEP);
  localparam logic [9:0] SIZE_M1_POS = 10'(SPRITE_SIZE - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  move_state_t      state_reg;
  dir_t             dir_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [9:0]       x_reg;
  logic [9:0]       y_reg;
  logic             deny_reg;
  logic             moving_reg;
  logic             blocked_reg;
  logic [15:0]      move_count_reg;

  // -------------------------------------------------------------------------
  // Key decode and frame divider
  // -------------------------------------------------------------------------
  dir_t             key_dir;
  logic [DIV_W-1:0] eff_cnt;
  logic             div_hit;

  key_decode u_key_decode (
    .keycode (keycode),
    .dir     (key_dir)
  );

  // A direction change restarts the hold count from zero on this very frame,
  // so a new key must be held for the full FRAME_DIV frames before stepping.
  always_comb begin
    eff_cnt = div_cnt_reg;
    if (key_dir != dir_reg) begin
      eff_cnt = '0;
    end
    div_hit = (eff_cnt == DIV_LAST);
  end

  // -------------------------------------------------------------------------
  // Deny selection and screen-bound check for the latched direction
  // -------------------------------------------------------------------------
  logic        deny_sel;
  logic        bound_fail;
  logic [10:0] top_ext;
  logic [10:0] bottom_ext;
  logic [10:0] left_ext;
  logic [10:0] right_ext;

  always_comb begin
    deny_sel = 1'b0;
    case (dir_reg)
      DIR_UP:    deny_sel = deny_up;
      DIR_DOWN:  deny_sel = deny_down;
      DIR_LEFT:  deny_sel = deny_left;
      DIR_RIGHT: deny_sel = deny_right;
      default:   deny_sel = 1'b0;
    endcase
  end

  always_comb begin
    top_ext    = {1'b0, y_reg};
    left_ext   = {1'b0, x_reg};
    bottom_ext = top_ext + SIZE_M1;
    right_ext  = left_ext + SIZE_M1;
    bound_fail = 1'b0;
    case (dir_reg)
      DIR_UP:    bound_fail = (top_ext < STEP_EXT);
      DIR_DOWN:  bound_fail = ((bottom_ext + STEP_EXT) > MAX_Y_EXT);
      DIR_LEFT:  bound_fail = (left_ext < STEP_EXT);
      DIR_RIGHT: bound_fail = ((right_ext + STEP_EXT) > MAX_X_EXT);
      default:   bound_fail = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Step sequencer and position datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= ST_IDLE;
      dir_reg        <= DIR_NONE;
      div_cnt_reg    <= '0;
      x_reg          <= START_X_POS;
      y_reg          <= START_Y_POS;
      deny_reg       <= 1'b0;
      moving_reg     <= 1'b0;
      blocked_reg    <= 1'b0;
      move_count_reg <= '0;
    end else begin
      blocked_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (frame_tick) begin
            if (key_dir == DIR_NONE) begin
              // Releasing the key abandons any partial hold.
              div_cnt_reg <= '0;
            end else begin
              dir_reg <= key_dir;
              if (div_hit) begin
                div_cnt_reg <= '0;
                state_reg   <= ST_SETTLE;
                moving_reg  <= 1'b1;
              end else begin
                div_cnt_reg <= eff_cnt + DIV_W'(1);
              end
            end
          end
        end

        ST_SETTLE: begin
          // The box has been stable for a full cycle; the checkers' answer
          // for the latched direction is now trustworthy.
          deny_reg  <= deny_sel;
          state_reg <= ST_APPLY;
        end

        ST_APPLY: begin
          if (deny_reg || bound_fail) begin
            blocked_reg <= 1'b1;
          end else begin
            case (dir_reg)
              DIR_UP:    y_reg <= y_reg - STEP_POS;
              DIR_DOWN:  y_reg <= y_reg + STEP_POS;
              DIR_LEFT:  x_reg <= x_reg - STEP_POS;
              DIR_RIGHT: x_reg <= x_reg + STEP_POS;
              default:   x_reg <= x_reg;
            endcase
            if (move_count_reg != 16'hFFFF) begin
              move_count_reg <= move_count_reg + 16'd1;
            end
          end
          state_reg  <= ST_IDLE;
          moving_reg <= 1'b0;
        end

        default: begin
          state_reg  <= ST_IDLE;
          moving_reg <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign top        = y_reg;
  assign left       = x_reg;
  assign bottom     = y_reg + SIZE_M1_POS;
  assign right      = x_reg + SIZE_M1_POS;
  assign moving     = moving_reg;
  assign blocked    = blocked_reg;
  assign move_count = move_count_reg;

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Sequential player-position stage driving the deny_up/down/left/right checkers.
- Holds the player sprite bounding box (top, bottom, left, right) and presents it to the checkers.
- On each frame tick it reads the keycode, waits for the deny signals to settle against the current box, then commits one step or refuses it.
- Output feeds the deny checkers and the sprite/colour mapper.

Parameters:
START_X, 16, reset left edge (pixels)
START_Y, 16, reset top edge (pixels)
SPRITE_SIZE, 12, sprite width = height (pixels)
STEP, 2, pixels moved per committed step
FRAME_DIV, 2, frames a key must be held per step (>=1)
SCREEN_W, 640, screen width
SCREEN_H, 480, screen height

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-Clk pulse per video frame
keycode  input  8  current USB HID keycode (0x1A=W up, 0x16=S down, 0x04=A left, 0x07=D right, other=none)
deny_up  input  1  move-up blocked by maze, from current box
deny_down  input  1  move-down blocked
deny_left  input  1  move-left blocked
deny_right  input  1  move-right blocked
top  output  10  sprite top edge
bottom  output  10  sprite bottom edge = top+SPRITE_SIZE-1
left  output  10  sprite left edge
right  output  10  sprite right edge = left+SPRITE_SIZE-1
moving  output  1  high in SETTLE/APPLY
blocked  output  1  one-Clk pulse when a requested step is refused
move_count  output  16  committed steps, saturates at 0xFFFF

Behaviour:
- Reset (sync, high at Clk edge): left=START_X, top=START_Y, bottom/right derived, state=IDLE, div_cnt=0, dir=NONE, moving=0, blocked=0, move_count=0. Reset overrides any in-flight step.
- Position registers hold only x=left and y=top; bottom/right are combinational from them; all outputs change only at Clk edges.
- States: IDLE, SETTLE, APPLY.
- IDLE: on frame_tick, decode keycode -> dir.
  - dir=NONE: div_cnt<=0, stay IDLE.
  - Otherwise, if dir differs from the previously latched dir, div_cnt<=0 and latch the new dir.
  - If div_cnt==FRAME_DIV-1: div_cnt<=0, go to SETTLE. Else div_cnt++.
- SETTLE: one Clk so combinational deny checkers see a stable box. Register the selected deny_* at the end of this cycle. Go to APPLY.
- APPLY: a step is refused if the registered deny is set or the screen bound fails:
  - up: top<STEP
  - down: bottom+STEP>SCREEN_H-1
  - left: left<STEP
  - right: right+STEP>SCREEN_W-1
- APPLY outcome: if refused, pulse blocked and leave position unchanged. Else update by ±STEP and increment move_count (saturating). Return to IDLE.
- Bound arithmetic uses 11-bit intermediates; no wrap.
- frame_tick during SETTLE/APPLY is dropped, not queued.
- Keycode changes after latching are ignored until the next IDLE tick.
- Latency: frame_tick to committed position = 3 Clk edges (IDLE->SETTLE, SETTLE->APPLY, APPLY writes).
- moving=1 exactly in SETTLE and APPLY.

Decomposition:
- Shared package maze_pkg:
  - dir_t enum {NONE, UP, DOWN, LEFT, RIGHT}
  - keycode constants KEY_W/KEY_A/KEY_S/KEY_D
  - SCREEN_W/SCREEN_H defaults
  - state enum
- Sub-module key_decode (keycode -> dir_t, combinational) is natural. The FSM and position datapath stay in player_move_ctrl.

Test Plan:
- Reset then idle 5 frames, keycode=0 -> left=16, top=16, right=27, bottom=27, move_count=0, moving never high.
- keycode=0x07 held 4 frames, FRAME_DIV=2, all deny=0 -> left 16->18->20 (steps on frames 2 and 4), right tracks +11, move_count=2, each commit 3 Clk after its tick.
- keycode=0x1A held, deny_up=1 -> top stays 16, blocked pulses one Clk per attempt, move_count unchanged.
- START_Y=1, keycode=0x1A, deny_up=0 -> top<STEP, step refused, blocked=1, top=1.
- Key change 0x07->0x04 after first frame -> div_cnt restarts, first left step only after 2 further frames with 0x04.
- Reset asserted in SETTLE -> next edge state=IDLE, position=START, no commit, blocked=0.
